dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory (`dataMemory`/`genericRAM`, write-on-clock, registered read address) between the CPU load/store path (port 0) and a secondary master such as a program loader or debug port (port 1). It grants at most one access per cycle, drives the memory port combinationally from the winner, and returns read data with a one-cycle valid strobe to the requester that issued the read. A lock input allows short bursts, and a hold counter bounds them.

## Interface
- `dataW`, 32, data width
- `addrW`, 16, word address width
- `MAXHOLD`, 4, maximum consecutive locked grants to one port while the other port waits (≥1)
- `sysCLK`  in  1  system clock, all state on rising edge
- `sysRST`  in  1  reset, asynchronous, active-high
- `r0Req`, `r1Req`  in  1  access request
- `r0WE`, `r1WE`  in  1  1 = write, 0 = read
- `r0Lock`, `r1Lock`  in  1  request to keep the grant next cycle
- `r0Addr`, `r1Addr`  in  addrW  word address
- `r0WData`, `r1WData`  in  dataW  write data
- `r0Gnt`, `r1Gnt`  out  1  access accepted this cycle (combinational)
- `r0RValid`, `r1RValid`  out  1  read data valid this cycle
- `r0RData`, `r1RData`  out  dataW  read data, zero when RValid = 0
- `memAddr`  out  addrW  to memory `addr`
- `memDataW`  out  dataW  to memory `dataIN`
- `memRW`  out  1  to memory `enWR`
- `memDataR`  in  dataW  from memory `Q`

## Operation
- State: `IDLE`, `OWN0`, `OWN1` (locked owner). Also a 1-bit round-robin pointer `prio`, a hold counter `holdCnt` (clog2(MAXHOLD+1) bits), and a read-return register `{rdPend, rdPort}`.
- Grant in `IDLE`:
  - If only one port requests, that port wins.
  - If both request, port `prio` wins.
- Grant in `OWNx`: port x wins if `rxReq`=1, unless the other port requests and `holdCnt` = MAXHOLD. In that case the other port wins, and the state goes to `IDLE` (or to the other port's `OWN` state if it locks).
- If the owner drops `Req`, arbitration runs as in `IDLE` that same cycle.
- Next state after a grant to port x: `OWNx` if `rxLock`=1, else `IDLE`.
- No grant in a cycle: state goes to `IDLE`.
- `holdCnt`:
  - Increments on each grant to the current owner while the other port requests. Saturates at MAXHOLD.
  - Clears on an ownership change, on a return to `IDLE`, or on any cycle in which the other port does not request.
- `prio` (with `DMEM_ARB_RR_EN`): after a grant to port x, `prio` becomes the other port.
- Memory mux:
  - `memAddr`/`memDataW` come from the winner.
  - With no winner, they hold 0.
  - `memRW` = winner's `WE`, and 0 with no winner.
- A read grant sets `rdPend`=1 and `rdPort`=winner for the next cycle.
- In that next cycle, the selected port's `RValid`=1 and its `RData`=`memDataR`. The other port's `RData`=0.
- Writes produce no `RValid`.
- Back-to-back reads from either port are allowed every cycle.

## Timing
- Grant and memory outputs are combinational from Req/state in the same cycle. The memory samples them on the next rising edge.
- Read latency: data is returned exactly 1 cycle after the grant cycle. The `RValid` pulse is 1 cycle wide.
- Write latency: the data is in memory after the grant edge. A read granted in the following cycle returns the new data.
- Reset (`sysRST`=1, async): state=`IDLE`, `prio`=0, `holdCnt`=0, `rdPend`=0.
- During reset, all `Gnt`, `RValid` and `memRW` are forced to 0, and `memAddr`/`memDataW`/`RData` are 0.
- Reset mid-burst or with a read pending: the pending `RValid` is dropped, and no memory write happens on any edge while `sysRST`=1.
- First edge after reset release: normal arbitration. Port 0 wins a tie.

## Configuration
- `DMEM_ARB_RR_EN` defined: ties in `IDLE` are resolved round-robin via `prio` as above.
- Not defined: fixed priority. Port 0 always wins ties, and `prio` is removed (stays 0).
- Lock and `MAXHOLD` behave the same in both builds, so port 1 is still guaranteed service after at most MAXHOLD locked port-0 grants.

## Test plan
- Reset with `r0Req`=1 held high -> `r0Gnt`=0, `memRW`=0, `r0RValid`=0; on release, `r0Gnt`=1 in the first cycle.
- Port 0 writes 0xDEADBEEF to addr 0x0010, then reads 0x0010 the next cycle -> `r0RValid`=1 one cycle after the read grant with `r0RData`=0xDEADBEEF; `r1RValid`=0 and `r1RData`=0 throughout.
- Both ports read continuously without lock, RR build -> grants alternate 0,1,0,1; each `RValid` lands on the correct port 1 cycle later. Fixed build -> `r0Gnt` every cycle and `r1Gnt` never.
- Port 0 holds Req+Lock for 10 cycles while port 1 requests, MAXHOLD=4 -> port 0 gets 4 consecutive grants, then port 1 is granted for 1 cycle, then port 0 resumes.
- Reset asserted one cycle after a port 1 read grant -> no `r1RValid` pulse; state `IDLE`; memory contents unchanged.
- Simultaneous write by port 0 and read by port 1 to the same address, with port 1 winning the tie (prio=1) -> port 1 reads the old value; port 0 is granted next cycle and its write lands.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU path (port 0) and a secondary master (port 1).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking in IDLE; without it port 0 always wins ties.
//   state | meaning
//   IDLE  | no locked owner, plain arbitration
//   OWN0  | port 0 locked the grant last cycle
//   OWN1  | port 1 locked the grant last cycle
module dmem_arbiter #(
  parameter int dataW   = 32,
  parameter int addrW   = 16,
  parameter int MAXHOLD = 4
) (
  input  logic             sysCLK,
  input  logic             sysRST,
  input  logic             r0Req,
  input  logic             r0WE,
  input  logic             r0Lock,
  input  logic [addrW-1:0] r0Addr,
  input  logic [dataW-1:0] r0WData,
  input  logic             r1Req,
  input  logic             r1WE,
  input  logic             r1Lock,
  input  logic [addrW-1:0] r1Addr,
  input  logic [dataW-1:0] r1WData,
  output logic             r0Gnt,
  output logic             r1Gnt,
  output logic             r0RValid,
  output logic             r1RValid,
  output logic [dataW-1:0] r0RData,
  output logic [dataW-1:0] r1RData,
  output logic [addrW-1:0] memAddr,
  output logic [dataW-1:0] memDataW,
  output logic             memRW,
  input  logic [dataW-1:0] memDataR
);

  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [HW-1:0] holdCnt, hold_nxt, hold_inc;
  logic          prio;
  logic          rdPend, rdPort;
  logic          win0, win1;
  logic          hold_full;

  assign hold_full = (holdCnt == HOLD_MAX);
  assign hold_inc  = hold_full ? HOLD_MAX : holdCnt + HOLD_ONE;

  // A locked owner keeps the port until the waiting side has seen MAXHOLD grants go by.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (state == OWN0 && r0Req) begin
      if (r1Req && hold_full) win1 = 1'b1;
      else                    win0 = 1'b1;
    end else if (state == OWN1 && r1Req) begin
      if (r0Req && hold_full) win0 = 1'b1;
      else                    win1 = 1'b1;
    end else if (r0Req && r1Req) begin
      win0 = ~prio;
      win1 = prio;
    end else begin
      win0 = r0Req;
      win1 = r1Req;
    end
    if (sysRST) begin
      win0 = 1'b0;
      win1 = 1'b0;
    end
  end

  // The grant that opens a locked burst counts toward the hold limit.
  always_comb begin
    state_nxt = IDLE;
    hold_nxt  = '0;
    if (win0 && r0Lock) begin
      state_nxt = OWN0;
      if (r1Req) hold_nxt = (state == OWN0) ? hold_inc : HOLD_ONE;
    end else if (win1 && r1Lock) begin
      state_nxt = OWN1;
      if (r0Req) hold_nxt = (state == OWN1) ? hold_inc : HOLD_ONE;
    end
  end

  always_ff @(posedge sysCLK or posedge sysRST) begin
    if (sysRST) begin
      state   <= IDLE;
      holdCnt <= '0;
      rdPend  <= 1'b0;
      rdPort  <= 1'b0;
    end else begin
      state   <= state_nxt;
      holdCnt <= hold_nxt;
      rdPend  <= (win0 & ~r0WE) | (win1 & ~r1WE);
      rdPort  <= win1;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge sysCLK or posedge sysRST) begin
    if (sysRST)    prio <= 1'b0;
    else if (win0) prio <= 1'b1;
    else if (win1) prio <= 1'b0;
  end
`else
  assign prio = 1'b0;
`endif

  assign r0Gnt    = win0;
  assign r1Gnt    = win1;
  assign r0RValid = rdPend & ~rdPort & ~sysRST;
  assign r1RValid = rdPend &  rdPort & ~sysRST;
  assign r0RData  = r0RValid ? memDataR : '0;
  assign r1RData  = r1RValid ? memDataR : '0;

  assign memAddr  = win0 ? r0Addr  : (win1 ? r1Addr  : '0);
  assign memDataW = win0 ? r0WData : (win1 ? r1WData : '0);
  assign memRW    = (win0 & r0WE) | (win1 & r1WE);

endmodule
